btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Input conditioning stage that sits directly upstream of the `msr` button decoder in the stopwatch top level. It synchronises the raw mechanical button lines, debounces each one independently, and produces a clean level per button. It also produces single-cycle press and release pulses, so the decoder and counter act exactly once per physical press. An optional hold-to-repeat feature re-fires press pulses while a button stays down, for fast minute/second setting.

## Interface
- `N_BTN`, default 3: number of button channels (m, s, r).
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a change (20 ms at 50 MHz); minimum 2.
- `REPEAT_DELAY`, default 25_000_000: held cycles before the first auto-repeat pulse (0.5 s).
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent auto-repeat pulses (0.1 s).
- `clk`, in, 1: single system clock; all logic is clocked on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `btn_raw`, in, N_BTN: asynchronous raw button inputs, active-high.
- `btn_level`, out, N_BTN: debounced, registered button state.
- `btn_press`, out, N_BTN: one-cycle pulse on an accepted 0→1 transition, plus auto-repeat pulses.
- `btn_release`, out, N_BTN: one-cycle pulse on an accepted 1→0 transition.

## Operation
- Each channel is fully independent; there is no cross-channel priority or arbitration.
- Synchroniser: two flops per channel (`sync1`, `sync2`); all downstream logic uses only `sync2`.
- Debounce: per-channel counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`.
  - If `sync2 == btn_level`, then `cnt <= 0`.
  - Otherwise `cnt` increments by 1.
  - When `sync2` differs and `cnt == DEBOUNCE_CYCLES-1`: `btn_level` toggles and `cnt <= 0`.
  - Any single-cycle agreement between `sync2` and `btn_level` restarts the count. A glitch shorter than `DEBOUNCE_CYCLES` therefore never propagates.
- Pulses are registered and asserted in the same cycle `btn_level` changes: `btn_press` on 0→1, `btn_release` on 1→0.
- `btn_press` and `btn_release` are never high together on one channel.
- Reset: `sync1`, `sync2`, `btn_level`, `btn_press`, `btn_release`, all counters and repeat state go to 0 / IDLE.
  - A button held through reset is detected as a fresh press after the normal latency.
  - Reset mid-debounce discards the partial count.
- Repeat FSM (only with `BTN_REPEAT_EN`), per channel:
  - IDLE → DELAY on the accepted press. `rcnt` clears.
  - DELAY: `rcnt` increments each cycle. At `rcnt == REPEAT_DELAY-1`, pulse `btn_press`, clear `rcnt`, and go to REPEAT.
  - REPEAT: at `rcnt == REPEAT_PERIOD-1`, pulse `btn_press` and clear `rcnt`. The state is unchanged.
  - From any state, `btn_level` falling returns to IDLE in the same cycle the release pulse fires. No repeat pulse is issued in that cycle.
  - `rcnt` width is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD))`. It saturates by construction and never wraps.

## Timing
- A raw edge sampled at rising edge t first reaches `sync2` after edge t+1.
- `btn_level` and its pulse change at edge t+1+DEBOUNCE_CYCLES, i.e. total latency is `DEBOUNCE_CYCLES+2` cycles from the raw change to the visible output.
- Press and release pulses are exactly 1 cycle wide.
- Minimum spacing between two accepted transitions on one channel is `DEBOUNCE_CYCLES` cycles.
- First repeat pulse: `REPEAT_DELAY` cycles after the original press pulse. Later repeats are spaced `REPEAT_PERIOD` cycles apart.

## Configuration
- `BTN_REPEAT_EN` defined: the repeat FSM and `rcnt` are compiled in, and `btn_press` carries repeat pulses.
- `BTN_REPEAT_EN` undefined:
  - No repeat logic is generated.
  - `btn_press` fires exactly once per accepted press.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Structure
- Shared package `clock_pkg` holds:
  - `CLK_HZ` (50_000_000);
  - the default debounce/repeat cycle constants, derived from `CLK_HZ`;
  - the `btn_idx_e` enum (`BTN_M=0`, `BTN_S=1`, `BTN_R=2`) used by both this block and the decoder.
- The repeat FSM state typedef `rep_state_e` (IDLE, DELAY, REPEAT) also lives in `clock_pkg`.
- Sub-module `btn_channel`: one synchroniser, debounce counter, pulse generator and optional repeat FSM. The top generates `N_BTN` instances of it.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.

- Reset: assert `rst` for 3 cycles with `btn_raw=3'b111` → all outputs read 0 during reset. After release, `btn_level=3'b111` and `btn_press=3'b111` for one cycle, exactly 6 cycles later.
- Bounce rejection: ch0 toggles 1,0,1,0 with 1-cycle, 2-cycle and 3-cycle high pulses → `btn_level[0]` stays 0, no pulses.
- Clean press/release: ch1 high for 20 cycles, then low → `btn_press[1]` pulses 6 cycles after the rise, `btn_release[1]` pulses 6 cycles after the fall, and each is 1 cycle wide.
- Independence: ch0 and ch2 rise on the same edge, ch1 stays idle → both press pulses land in the same cycle, and ch1 stays quiet.
- Repeat (`BTN_REPEAT_EN`): hold ch0 for 30 cycles after acceptance → press pulses at offsets 0, 10, 13, 16, 19, 22, 25, 28. Release stops them, with no press pulse in the release cycle.
- Without `BTN_REPEAT_EN`: same 30-cycle hold → exactly one `btn_press` pulse.

Source files
------------

// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg: shared stopwatch clock constants, button indices, repeat states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clock_pkg;

  localparam int CLK_HZ = 50_000_000;

  // Debounce 20 ms, first repeat after 0.5 s, then every 0.1 s
  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;
  localparam int REPEAT_DELAY_DEF    = CLK_HZ / 2;
  localparam int REPEAT_PERIOD_DEF   = CLK_HZ / 10;

  typedef enum logic [1:0] {
    BTN_M = 2'd0,
    BTN_S = 2'd1,
    BTN_R = 2'd2
  } btn_idx_e;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// ---------------------------------------------------------------------------
// btn_channel: synchroniser, debounce, press/release pulses and optional
// hold-to-repeat (compiled in with BTN_REPEAT_EN).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_channel
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic          level_d;
  logic          press_d;
  logic          rel_d;

`ifdef BTN_REPEAT_EN
  localparam int RCW = imax(1, $clog2(imax(REPEAT_DELAY, REPEAT_PERIOD)));
  localparam logic [RCW-1:0] DELAY_MAX  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_MAX = RCW'(REPEAT_PERIOD - 1);

  rep_state_e     rstate;
  rep_state_e     rstate_d;
  logic [RCW-1:0] rcnt;
  logic [RCW-1:0] rcnt_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  always_comb begin
    level_d = level;
    cnt_d   = cnt;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (sync2 == level) begin
      cnt_d = '0;
    end else if (cnt == CNT_MAX) begin
      level_d = sync2;
      cnt_d   = '0;
      press_d = sync2;
      rel_d   = ~sync2;
    end else begin
      cnt_d = cnt + CW'(1);
    end
`ifdef BTN_REPEAT_EN
    rstate_d = rstate;
    rcnt_d   = rcnt;
    // A release always wins: back to idle with no repeat pulse this cycle
    if (rel_d) begin
      rstate_d = REP_IDLE;
      rcnt_d   = '0;
    end else begin
      unique case (rstate)
        REP_IDLE: begin
          if (press_d) begin
            rstate_d = REP_DELAY;
            rcnt_d   = '0;
          end
        end
        REP_DELAY: begin
          if (rcnt == DELAY_MAX) begin
            press_d  = 1'b1;
            rcnt_d   = '0;
            rstate_d = REP_REPEAT;
          end else begin
            rcnt_d = rcnt + RCW'(1);
          end
        end
        REP_REPEAT: begin
          if (rcnt == PERIOD_MAX) begin
            press_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt + RCW'(1);
          end
        end
        default: rstate_d = REP_IDLE;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      level <= level_d;
      press <= press_d;
      rel   <= rel_d;
      cnt   <= cnt_d;
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate <= REP_IDLE;
      rcnt   <= '0;
    end else begin
      rstate <= rstate_d;
      rcnt   <= rcnt_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner: N_BTN independent button channels feeding the msr decoder;
// hold-to-repeat enabled by BTN_REPEAT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_conditioner
  import clock_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_channel (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner: directed and random stimulus against a window-based
// reference model of btn_conditioner.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_btn_conditioner;

  localparam int N    = 3;
  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int MAXC = 2048;
`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int n_checks = 0;
  int n_fail   = 0;

  btn_conditioner #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  // Reference model: a change is accepted once the synchronised input has
  // disagreed with the level for D consecutive cycles since the last change.
  int           k = 0;
  bit           s_hist [N][MAXC];
  bit           m_sy1  [N];
  int           last_t [N] = '{MAXC, MAXC, MAXC};
  int           p_edge [N];
  logic [N-1:0] m_lvl   = '0;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_rel   = '0;

  always @(posedge clk) begin
    if (k >= MAXC) begin
      $display("FAIL model_history: cycle budget %0d exhausted", MAXC);
      $fatal(1);
    end
    for (int ch = 0; ch < N; ch++) begin
      bit tog;
      m_press[ch] = 1'b0;
      m_rel[ch]   = 1'b0;
      if (rst) begin
        m_sy1[ch]     = 1'b0;
        s_hist[ch][k] = 1'b0;
        last_t[ch]    = k;
        m_lvl[ch]     = 1'b0;
      end else begin
        tog = (k - D >= last_t[ch]);
        for (int j = k - D; j < k; j++)
          if (tog && (s_hist[ch][j] == m_lvl[ch])) tog = 1'b0;
        if (tog) begin
          m_lvl[ch]  = ~m_lvl[ch];
          last_t[ch] = k;
          if (m_lvl[ch]) begin
            m_press[ch] = 1'b1;
            p_edge[ch]  = k;
          end else begin
            m_rel[ch] = 1'b1;
          end
        end else if (REP_EN && m_lvl[ch] && (k - p_edge[ch] >= RD) &&
                     ((k - p_edge[ch] - RD) % RP == 0)) begin
          m_press[ch] = 1'b1;
        end
        s_hist[ch][k] = m_sy1[ch];
        m_sy1[ch]     = btn_raw[ch];
      end
    end
    k++;
  end

  task automatic test_reset();
    rst     = 1'b1;
    btn_raw = 3'b111;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b/%b/%b required 000/000/000",
                 btn_level, btn_press, btn_release);
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (btn_level !== ((c >= 6) ? 3'b111 : 3'b000)) begin
        n_fail++;
        $display("FAIL reset_level c=%0d: got %b", c, btn_level);
      end
      n_checks++;
      if (btn_press !== ((c == 6) ? 3'b111 : 3'b000)) begin
        n_fail++;
        $display("FAIL reset_press c=%0d: got %b", c, btn_press);
      end
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL reset_model c=%0d: got %b/%b/%b expected %b/%b/%b", c,
                 btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
    end
    btn_raw = 3'b000;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL reset_drop_model c=%0d: got %b/%b/%b expected %b/%b/%b", c,
                 btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
    end
  endtask

  task automatic test_bounce();
    int vals [6] = '{1, 0, 1, 0, 1, 0};
    int lens [6] = '{1, 3, 2, 3, 3, 8};
    for (int s = 0; s < 6; s++) begin
      btn_raw = {2'b00, vals[s][0]};
      for (int c = 0; c < lens[s]; c++) begin
        @(negedge clk);
        n_checks++;
        if ({btn_level[0], btn_press[0], btn_release[0]} !== 3'b000) begin
          n_fail++;
          $display("FAIL bounce_ch0 seg=%0d: got lvl/prs/rel %b%b%b required 000",
                   s, btn_level[0], btn_press[0], btn_release[0]);
        end
        n_checks++;
        if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
          n_fail++;
          $display("FAIL bounce_model: got %b/%b/%b expected %b/%b/%b",
                   btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
        end
      end
    end
  endtask

  task automatic test_clean_press();
    btn_raw = 3'b010;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_level[1], btn_press[1], btn_release[1]} !==
          {1'(c >= 6 && c < 26), 1'(c == 6), 1'(c == 26)}) begin
        n_fail++;
        $display("FAIL clean_ch1 c=%0d: got lvl/prs/rel %b%b%b required %b%b%b", c,
                 btn_level[1], btn_press[1], btn_release[1],
                 1'(c >= 6 && c < 26), 1'(c == 6), 1'(c == 26));
      end
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL clean_model c=%0d: got %b/%b/%b expected %b/%b/%b", c,
                 btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
      if (c == 20) btn_raw = 3'b000;
    end
  endtask

  task automatic test_independence();
    btn_raw = 3'b101;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        n_checks++;
        if (btn_press !== ((c == 6) ? 3'b101 : 3'b000)) begin
          n_fail++;
          $display("FAIL indep_press c=%0d: got %b required %b", c, btn_press,
                   (c == 6) ? 3'b101 : 3'b000);
        end
      end
      n_checks++;
      if ({btn_level[1], btn_press[1], btn_release[1]} !== 3'b000) begin
        n_fail++;
        $display("FAIL indep_ch1_quiet c=%0d: got %b%b%b", c,
                 btn_level[1], btn_press[1], btn_release[1]);
      end
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL indep_model c=%0d: got %b/%b/%b expected %b/%b/%b", c,
                 btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
      if (c == 8) btn_raw = 3'b000;
    end
  endtask

  task automatic test_reset_mid();
    btn_raw = 3'b010;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({btn_level, btn_press, btn_release} !== 9'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b/%b/%b required 0", btn_level,
               btn_press, btn_release);
    end
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      n_checks++;
      if (c <= 8 && btn_press[1] !== 1'(c == 6)) begin
        n_fail++;
        $display("FAIL midreset_press c=%0d: got %b required %b", c,
                 btn_press[1], 1'(c == 6));
      end
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL midreset_model c=%0d: got %b/%b/%b expected %b/%b/%b", c,
                 btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
      if (c == 8) btn_raw = 3'b000;
    end
  endtask

  task automatic test_repeat();
    bit found = 1'b0;
    int count = 1;
    btn_raw = 3'b001;
    for (int c = 1; c <= 12 && !found; c++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL repeat_accept_model c=%0d: got %b/%b/%b expected %b/%b/%b", c,
                 btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
      if (btn_press[0] === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL repeat_accept: got no press within 12 cycles required one");
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (btn_press[0] === 1'b1) count++;
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL repeat_model c=%0d: got %b/%b/%b expected %b/%b/%b", c,
                 btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
      if (c == 31) begin
        n_checks++;
        if ({btn_press[0], btn_release[0]} !== 2'b01) begin
          n_fail++;
          $display("FAIL repeat_release_cycle: got prs/rel %b%b required 01",
                   btn_press[0], btn_release[0]);
        end
      end
      if (c == 25) btn_raw = 3'b000;
    end
    n_checks++;
    if (count != (REP_EN ? 8 : 1)) begin
      n_fail++;
      $display("FAIL repeat_count: got %0d press pulses required %0d", count,
               REP_EN ? 8 : 1);
    end
  endtask

  task automatic test_random();
    int rem [N] = '{0, 0, 0};
    for (int c = 0; c < 600; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (rem[ch] == 0) begin
          btn_raw[ch] = ~btn_raw[ch];
          rem[ch]     = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30)
                                                   : $urandom_range(1, 6);
        end
        rem[ch]--;
      end
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL random_model c=%0d: got %b/%b/%b expected %b/%b/%b", c,
                 btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
      end
      n_checks++;
      if ((btn_press & btn_release) !== 3'b000) begin
        n_fail++;
        $display("FAIL random_exclusive c=%0d: got press&release %b required 000",
                 c, btn_press & btn_release);
      end
    end
    btn_raw = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_independence();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
